max_selector_seq: RTL and testbench
===================================

# max_selector_seq

Sequential N-sample maximum selector, the streaming successor of the 2-input combinational max selector. A `start` pulse opens a scan. The block then accepts `COUNT` samples one per cycle under a `valid` qualifier and tracks the running maximum and its position. It reports the result with a one-cycle `done` pulse. Unsigned or two's-complement comparison is selectable by parameter. It sits between a sample source (counter, switch bank, ADC sampler) and a display or decision stage.

## Interface
- `WIDTH`, 4: sample and result width in bits, ≥1.
- `COUNT`, 8: samples per scan, ≥2.
- `SIGNED`, 0: 0 = unsigned compare; 1 = two's-complement compare.
- Derived `IW` = `$clog2(COUNT)`: index width.
- `clk` in 1: clock, all state updates on rising edge.
- `reset` in 1: synchronous, active-high reset.
- `start` in 1: begin a scan; honoured only in IDLE.
- `valid` in 1: `d` carries a sample this cycle; honoured only in SCAN.
- `d` in WIDTH: sample input.
- `busy` out 1: high in SCAN.
- `done` out 1: one-cycle pulse, result valid.
- `y` out WIDTH: maximum of last completed scan.
- `index` out IW: position (0-based, order of acceptance) of `y` in that scan.

## Operation
- States are IDLE, SCAN and DONE. A registered FSM drives them, and all outputs are registered.
- **IDLE:**
  - `start`=1 → SCAN next cycle.
  - Sample counter cleared.
  - `valid` ignored.
- **SCAN:**
  - Each edge with `valid`=1 accepts `d`.
  - Accepted sample 0 is loaded unconditionally into the running max and index.
  - Later samples replace the running max only if strictly greater. Ties keep the earliest index.
  - `valid`=0 cycles stall with no state change and are unlimited in number.
  - `start` is ignored.
- **Last sample:** the edge accepting sample `COUNT-1` moves to DONE. On the same edge, `y`/`index` load the final result, which includes that sample if it wins.
- **DONE:**
  - `done`=1 for exactly this cycle.
  - Next edge → IDLE unconditionally.
  - `start` in DONE is ignored.
- **Output hold:** `y`/`index` hold the last completed result through IDLE and the following SCAN. They change only at the completion of the next scan.
- **Comparison:**
  - SIGNED=0: `d` is unsigned.
  - SIGNED=1: MSB is the sign bit; e.g. WIDTH=4, 4'b0111 (7) > 4'b1111 (−1).
  - No widening and no arithmetic overflow is possible, since only compare and copy are performed.
- **Sample counter:** `$clog2(COUNT+1)` bits, never wraps.
- **Reset** (any state, including mid-scan):
  - Next state IDLE.
  - `busy`=0, `done`=0, `y`=0, `index`=0.
  - Running max and counter cleared.
  - A partial scan is discarded.

## Timing
- **Reset values:** `busy`=0, `done`=0, `y`='0, `index`='0.
- **Scan start:** `start` sampled high at edge E0 → `busy`=1 from E0.
- **Fastest scan (`valid` held high):** samples accepted at edges E1..E_COUNT.
  - `busy`=0 and `done`=1 from E_COUNT.
  - `done`=0 from E_COUNT+1.
  - Start-to-done latency is COUNT+1 cycles.
- **With valid gaps:** latency = 1 + number of cycles until COUNT accepts.
- **Back-to-back scans:** minimum start-to-start spacing is COUNT+2 cycles, since `start` must be seen in IDLE.
- **Simultaneous `start` and `valid` in IDLE:** `d` is not accepted; the first sample comes from the next cycle.
- **`reset` with any other input:** reset wins.

## Test plan
- **Unsigned ordering and tie.** WIDTH=4, COUNT=8, SIGNED=0, continuous `valid`, `d` = 3, 9, 1, 15, 15, 0, 7, 2.
  - Required: `done` pulse at cycle COUNT+1 after `start`, `y`=15, `index`=3.
  - `busy` high for exactly 8 cycles.
- **Signed mode.** SIGNED=1, `d` = 4'b1111, 4'b1000, 4'b0011, 4'b0111, 4'b1001, 4'b0000, 4'b0111, 4'b1110.
  - Required: `y`=4'b0111, `index`=3.
  - Same data with SIGNED=0 → `y`=4'b1111, `index`=0.
- **Stalls.** Same data as the unsigned test, `valid` toggled 1,0,1,0,…
  - Required: identical result `y`=15, `index`=3.
  - `done` 16 cycles after `start`.
- **Ignored controls.**
  - `start` pulsed mid-scan and during `done` → no restart, result unchanged.
  - `valid` with data 15 in IDLE → not counted.
- **Reset mid-scan.** Assert `reset` after 4 accepts.
  - Required: next cycle `busy`=0, `y`=0, `index`=0, no `done`.
  - A fresh scan of all-5 samples → `y`=5, `index`=0.
- **Result hold.** Run scan A (max 9), then scan B (max 12).
  - Required: `y`=9 held throughout scan B.
  - `y` switches to 12 exactly when `done` rises for B.

Source files
------------

// File: rtl/max_selector_seq.sv
// max_selector_seq: streaming COUNT-sample max finder with position, start/valid/done handshake
module max_selector_seq #(
  parameter int WIDTH = 4,
  parameter int COUNT = 8,
  parameter int SIGNED = 0,
  localparam int IW = $clog2(COUNT),
  localparam int CW = $clog2(COUNT + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             valid,
  input  logic [WIDTH-1:0] d,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] y,
  output logic [IW-1:0]    index
);
  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] max_q, max_d, y_q, y_d;
  logic [IW-1:0] idx_q, idx_d, index_q, index_d;
  logic busy_q, busy_d, done_q, done_d;
  logic gt, take, last;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    max_d = max_q;
    idx_d = idx_q;
    y_d = y_q;
    index_d = index_q;
    gt = (SIGNED != 0) ? ($signed(d) > $signed(max_q)) : (d > max_q);
    take = (cnt_q == '0) || gt;
    last = cnt_q == CW'(COUNT - 1);
    if (state_q == IDLE) begin
      cnt_d = '0;
      state_d = start ? SCAN : IDLE;
    end else if (state_q == SCAN) begin
      if (valid) begin
        max_d = take ? d : max_q;
        idx_d = take ? cnt_q[IW-1:0] : idx_q;
        cnt_d = cnt_q + CW'(1);
        state_d = last ? DONE : SCAN;
        y_d = last ? max_d : y_q;
        index_d = last ? idx_d : index_q;
      end
    end else begin
      state_d = IDLE;
    end
    busy_d = state_d == SCAN;
    done_d = state_d == DONE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      max_q <= '0;
      idx_q <= '0;
      y_q <= '0;
      index_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      max_q <= max_d;
      idx_q <= idx_d;
      y_q <= y_d;
      index_q <= index_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end
  assign busy = busy_q;
  assign done = done_q;
  assign y = y_q;
  assign index = index_q;
endmodule

// File: tb/tb_max_selector_seq.sv
// tb_max_selector_seq: random and directed scans on unsigned and signed instances vs a behavioural max model
module tb_max_selector_seq;
  localparam int COUNT = 8;
  logic clk = 0, reset = 1, start = 0, valid = 0;
  logic [3:0] d = '0;
  logic busy_u, done_u, busy_s, done_s;
  logic [3:0] y_u, y_s;
  logic [2:0] idx_u, idx_s;
  logic [3:0] smp [COUNT];
  logic [3:0] hy_u, hy_s;
  int hi_u, hi_s, n_chk, n_bad, lat;
  always #5 clk = ~clk;
  max_selector_seq #(.WIDTH(4), .COUNT(COUNT), .SIGNED(0)) dut_u (
    .clk(clk), .reset(reset), .start(start), .valid(valid), .d(d),
    .busy(busy_u), .done(done_u), .y(y_u), .index(idx_u));
  max_selector_seq #(.WIDTH(4), .COUNT(COUNT), .SIGNED(1)) dut_s (
    .clk(clk), .reset(reset), .start(start), .valid(valid), .d(d),
    .busy(busy_s), .done(done_s), .y(y_s), .index(idx_s));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic void ref_max(input bit sg, output logic [3:0] my, output int mi);
    int best, v;
    best = 0;
    my = '0;
    mi = 0;
    for (int i = 0; i < COUNT; i++) begin
      v = (sg && smp[i] >= 8) ? int'(smp[i]) - 16 : int'(smp[i]);
      if (i == 0 || v > best) begin
        best = v;
        mi = i;
        my = smp[i];
      end
    end
  endfunction
  task automatic load(input logic [31:0] w);
    for (int i = 0; i < COUNT; i++) smp[i] = w[4*(COUNT-1-i) +: 4];
  endtask
  task automatic scan(input int gm, input bit poke, input bit idle_valid, output int cyc);
    int k, bc, ei_u, ei_s;
    logic [3:0] ey_u, ey_s;
    ref_max(0, ey_u, ei_u);
    ref_max(1, ey_s, ei_s);
    start = 1;
    valid = idle_valid;
    d = 4'hF;
    @(negedge clk);
    start = 0;
    cyc = 1;
    k = 0;
    bc = 0;
    while (k < COUNT && cyc < 200) begin
      if (busy_u) bc++;
      chk("hold_y_u", y_u, hy_u);
      chk("hold_i_u", idx_u, hi_u);
      chk("hold_y_s", y_s, hy_s);
      chk("no_early_done", done_u, 0);
      valid = gm == 0 ? 1'b1 : gm == 1 ? (cyc % 2 == 1) : ($urandom % 3 != 0);
      start = poke && (cyc == 3);
      d = smp[k];
      @(negedge clk);
      if (valid) k++;
      cyc++;
    end
    valid = 0;
    start = poke;
    chk("timeout_accepts", k, COUNT);
    chk("busy_cycles", bc, cyc - 1);
    chk("done_u", done_u, 1);
    chk("done_s", done_s, 1);
    chk("busy_end", busy_u, 0);
    chk("y_u", y_u, ey_u);
    chk("idx_u", idx_u, ei_u);
    chk("y_s", y_s, ey_s);
    chk("idx_s", idx_s, ei_s);
    hy_u = ey_u; hi_u = ei_u; hy_s = ey_s; hi_s = ei_s;
    @(negedge clk);
    start = 0;
    chk("done_fall", done_u, 0);
    chk("no_restart", busy_u, 0);
    chk("keep_y", y_u, hy_u);
  endtask
  initial begin
    n_chk = 0; n_bad = 0;
    hy_u = 0; hy_s = 0; hi_u = 0; hi_s = 0;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy_u, 0);
    chk("rst_done", done_u, 0);
    chk("rst_y", y_u, 0);
    chk("rst_idx", idx_u, 0);
    reset = 0;
    valid = 1; d = 4'hF;
    repeat (3) @(negedge clk);
    chk("idle_valid_busy", busy_u, 0);
    valid = 0;
    load(32'h3911_F072);
    smp[3] = 4'hF; smp[4] = 4'hF;
    scan(0, 0, 1, lat);
    chk("t1_lat", lat, COUNT + 1);
    chk("t1_y", y_u, 15);
    chk("t1_idx", idx_u, 3);
    load(32'hF837_907E);
    scan(0, 1, 0, lat);
    chk("sgn_y", y_s, 4'b0111);
    chk("sgn_idx", idx_s, 3);
    chk("uns_y", y_u, 4'b1111);
    chk("uns_idx", idx_u, 0);
    load(32'h3910_0072);
    smp[3] = 4'hF; smp[4] = 4'hF;
    scan(1, 0, 0, lat);
    chk("stall_lat", lat, 16);
    chk("stall_y", y_u, 15);
    chk("stall_idx", idx_u, 3);
    start = 1;
    @(negedge clk);
    start = 0;
    valid = 1;
    d = 4'hE;
    repeat (4) @(negedge clk);
    reset = 1;
    @(negedge clk);
    reset = 0;
    valid = 0;
    chk("mid_rst_busy", busy_u, 0);
    chk("mid_rst_y", y_u, 0);
    chk("mid_rst_idx", idx_u, 0);
    chk("mid_rst_done", done_u, 0);
    hy_u = 0; hi_u = 0; hy_s = 0; hi_s = 0;
    repeat (10) begin
      @(negedge clk);
      chk("mid_rst_nodone", done_u, 0);
    end
    load(32'h5555_5555);
    scan(0, 0, 0, lat);
    chk("five_y", y_u, 5);
    chk("five_idx", idx_u, 0);
    load(32'h1293_4050);
    scan(2, 0, 0, lat);
    chk("scanA_y", y_u, 9);
    load(32'h3C21_0BC7);
    scan(2, 0, 0, lat);
    chk("scanB_y", y_u, 12);
    for (int t = 0; t < 25; t++) begin
      for (int i = 0; i < COUNT; i++) smp[i] = 4'($urandom);
      scan($urandom % 3, $urandom % 2, $urandom % 2, lat);
      repeat ($urandom % 3) @(negedge clk);
    end
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
